rf_wb_arbiter: RTL and testbench

// - Shares the single 64-bit register-file write port (writereg/rd/writedata) between two writeback requesters: ALU (req 0) and load unit (req 1).
// - Tracks a 32-entry pending-write scoreboard so decode can stall on RAW hazards.
// - Sits between the execute/memory stages and reg_file.
// - Outputs are registered and drive reg_file directly.

---
 rtl/rf_pkg.sv | 26 ++
 rtl/rf_rr_arb2.sv | 48 ++++
 rtl/rf_wb_arbiter.sv | 124 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
//   Shared types and sizes for the register-file writeback path.
//   DATA_W    writeback data width
//   ADDR_W    register index width (x0 is hardwired zero)
//   NUM_REGS  number of architectural registers / scoreboard entries
//   req_e     writeback requester identity (ALU or load unit)
//   wb_req_t  one writeback request: destination index plus data
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_rr_arb2.sv
// ---------------------------------------------------------------------------
// rf_rr_arb2
//   Two-input round-robin arbiter. The grant is combinational from the
//   request lines and the registered last_grant; last_grant moves only when
//   the consumer reports that a granted transfer actually happened.
//   clk      system clock, rising edge
//   reset    synchronous, active-high; last_grant returns to REQ_MEM so the
//            ALU wins the first tie
//   req      request lines, bit 0 = ALU, bit 1 = load unit
//   advance  a granted transfer took place this cycle
//   gnt      one-hot grant, or zero when nobody requests
// ---------------------------------------------------------------------------
module rf_rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    req_e last_grant;

    // NOTE: every always_comb output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On a tie the requester that did not win last time goes first.
            2'b11:   gnt = (last_grant == REQ_MEM) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= REQ_MEM;
        end else if (advance && (gnt != 2'b00)) begin
            last_grant <= gnt[1] ? REQ_MEM : REQ_ALU;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//   Shares the single register-file write port between the ALU (req 0) and
//   the load unit (req 1), keeps a pending-write scoreboard for decode's RAW
//   hazard stall, and counts accepted writebacks per requester.
//   clk, reset              clock / synchronous active-high reset
//   alu_valid/rd/data       ALU writeback offer;  alu_ready accepts it
//   mem_valid/rd/data       load writeback offer; mem_ready accepts it
//   issue_valid, issue_rd   decode issues an instruction that writes issue_rd
//   rs1, rs2                sources of the instruction in decode
//   stall                   RAW hazard on rs1/rs2 (combinational)
//   writereg, rd, writedata registered reg_file write port (latency 1)
//   alu_grants, mem_grants  saturating counts of accepted writebacks
// ---------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              stall,
    output logic              writereg,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] writedata,
    output logic [CNT_W-1:0]  alu_grants,
    output logic [CNT_W-1:0]  mem_grants
);

    // The request struct and scoreboard are sized from the package.
    if (DATA_W != rf_pkg::DATA_W || ADDR_W != rf_pkg::ADDR_W) begin : g_width_check
        $error("rf_wb_arbiter: DATA_W/ADDR_W must match rf_pkg");
    end

    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                xfer;
    logic                wr_en;
    wb_req_t             alu_req;
    wb_req_t             mem_req;
    wb_req_t             win;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    assign req = {mem_valid, alu_valid};

    rf_rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (xfer),
        .gnt     (gnt)
    );

    // Ready depends only on the valids and the arbiter state, never on data.
    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign xfer      = |gnt;

    assign alu_req = '{rd: alu_rd, data: alu_data};
    assign mem_req = '{rd: mem_rd, data: mem_data};
    assign win     = gnt[1] ? mem_req : alu_req;

    // x0 writebacks are accepted and counted but never reach the port.
    assign wr_en = xfer && (win.rd != '0);

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && (issue_rd != '0)) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (wr_en) begin
            clr_mask[win.rd] = 1'b1;
        end
    end

    // Clearing at the accept edge makes stall drop in the same cycle the
    // registered write reaches reg_file, whose read path is combinational.
    assign stall = ((rs1 != '0) && pending[rs1]) ||
                   ((rs2 != '0) && pending[rs2]);

    always_ff @(posedge clk) begin
        if (reset) begin
            writereg   <= 1'b0;
            rd         <= '0;
            writedata  <= '0;
            pending    <= '0;
            alu_grants <= '0;
            mem_grants <= '0;
        end else begin
            writereg <= wr_en;
            // rd/writedata hold when nothing is written.
            if (wr_en) begin
                rd        <= win.rd;
                writedata <= win.data;
            end
            // Set after clear: a same-cycle new producer keeps the bit pending.
            pending <= (pending & ~clr_mask) | set_mask;
            if (gnt[0] && (alu_grants != '1)) begin
                alu_grants <= alu_grants + CNT_W'(1);
            end
            if (gnt[1] && (mem_grants != '1)) begin
                mem_grants <= mem_grants + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//   Directed, table-driven bench for rf_wb_arbiter plus hand-written
//   sequences for reset mid-operation and counter saturation.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int CW = 16;
    localparam int NV = 16;

    typedef struct {
        logic          av;
        logic [AW-1:0] ard;
        logic [DW-1:0] ad;
        logic          mv;
        logic [AW-1:0] mrd;
        logic [DW-1:0] md;
        logic          iv;
        logic [AW-1:0] ird;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic          e_ar;
        logic          e_mr;
        logic          e_st;
        logic          e_wr;
        logic [AW-1:0] e_rd;
        logic [DW-1:0] e_wd;
        logic [CW-1:0] e_ac;
        logic [CW-1:0] e_mc;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, alu_ready, mem_valid, mem_ready;
    logic [AW-1:0] alu_rd, mem_rd, issue_rd, rs1, rs2, rd;
    logic [DW-1:0] alu_data, mem_data, writedata;
    logic          issue_valid, stall, writereg;
    logic [CW-1:0] alu_grants, mem_grants;

    // Second instance with narrow counters to reach saturation quickly.
    logic          s_alu_valid, s_alu_ready, s_mem_ready, s_stall, s_writereg;
    logic [AW-1:0] s_rd;
    logic [DW-1:0] s_writedata;
    logic [2:0]    s_alu_grants, s_mem_grants;

    int checks = 0;
    int errors = 0;
    vec_t vecs [NV];
    logic [31:0] tb_pend = '0;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
        .stall(stall), .writereg(writereg), .rd(rd), .writedata(writedata),
        .alu_grants(alu_grants), .mem_grants(mem_grants)
    );

    rf_wb_arbiter #(.CNT_W(3)) dut_s (
        .clk(clk), .reset(reset),
        .alu_valid(s_alu_valid), .alu_ready(s_alu_ready), .alu_rd(5'd3), .alu_data(64'h5),
        .mem_valid(1'b0), .mem_ready(s_mem_ready), .mem_rd(5'd0), .mem_data(64'h0),
        .issue_valid(1'b0), .issue_rd(5'd0), .rs1(5'd0), .rs2(5'd0),
        .stall(s_stall), .writereg(s_writereg), .rd(s_rd), .writedata(s_writedata),
        .alu_grants(s_alu_grants), .mem_grants(s_mem_grants)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
        input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
        input logic iv, input logic [AW-1:0] ird, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
        input logic e_ar, input logic e_mr, input logic e_st,
        input logic e_wr, input logic [AW-1:0] e_rd, input logic [DW-1:0] e_wd,
        input logic [CW-1:0] e_ac, input logic [CW-1:0] e_mc);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md;
        v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2;
        v.e_ar = e_ar; v.e_mr = e_mr; v.e_st = e_st;
        v.e_wr = e_wr; v.e_rd = e_rd; v.e_wd = e_wd; v.e_ac = e_ac; v.e_mc = e_mc;
        return v;
    endfunction

    task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                         input logic iv, input logic [AW-1:0] ird,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
    endtask

    initial begin
        //           av ard ad      mv mrd md      iv ird r1 r2   ar mr st  wr rd wd      ac mc
        vecs[0]  = mk(1, 5, 64'hAA, 0, 0, 64'h0,  0, 0,  0, 0,   1, 0, 0,  1, 5, 64'hAA, 1, 0);
        vecs[1]  = mk(0, 0, 64'h0,  1, 3, 64'h33, 0, 0,  0, 0,   0, 1, 0,  1, 3, 64'h33, 1, 1);
        vecs[2]  = mk(1, 1, 64'h11, 1, 2, 64'h22, 0, 0,  0, 0,   1, 0, 0,  1, 1, 64'h11, 2, 1);
        vecs[3]  = mk(1, 1, 64'h11, 1, 2, 64'h22, 0, 0,  0, 0,   0, 1, 0,  1, 2, 64'h22, 2, 2);
        vecs[4]  = mk(1, 1, 64'h11, 1, 2, 64'h22, 0, 0,  0, 0,   1, 0, 0,  1, 1, 64'h11, 3, 2);
        vecs[5]  = mk(1, 1, 64'h11, 1, 2, 64'h22, 0, 0,  0, 0,   0, 1, 0,  1, 2, 64'h22, 3, 3);
        vecs[6]  = mk(0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  0, 0,   0, 0, 0,  0, 2, 64'h22, 3, 3);
        vecs[7]  = mk(0, 0, 64'h0,  0, 0, 64'h0,  1, 7,  7, 0,   0, 0, 0,  0, 2, 64'h22, 3, 3);
        vecs[8]  = mk(0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  7, 0,   0, 0, 1,  0, 2, 64'h22, 3, 3);
        vecs[9]  = mk(0, 0, 64'h0,  1, 7, 64'h77, 0, 0,  7, 0,   0, 1, 1,  1, 7, 64'h77, 3, 4);
        vecs[10] = mk(0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  7, 0,   0, 0, 0,  0, 7, 64'h77, 3, 4);
        vecs[11] = mk(1, 9, 64'h99, 0, 0, 64'h0,  1, 9,  0, 9,   1, 0, 0,  1, 9, 64'h99, 4, 4);
        vecs[12] = mk(0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  0, 9,   0, 0, 1,  0, 9, 64'h99, 4, 4);
        vecs[13] = mk(1, 0, 64'hFF, 0, 0, 64'h0,  0, 0,  0, 9,   1, 0, 1,  0, 9, 64'h99, 5, 4);
        vecs[14] = mk(0, 0, 64'h0,  1, 9, 64'h9A, 0, 0,  0, 0,   0, 1, 0,  1, 9, 64'h9A, 5, 5);
        vecs[15] = mk(0, 0, 64'h0,  0, 0, 64'h0,  0, 0,  7, 9,   0, 0, 0,  0, 9, 64'h9A, 5, 5);

        reset = 1'b1;
        s_alu_valid = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_writereg", 64'(writereg), 64'h0);
        check("reset_rd", 64'(rd), 64'h0);
        check("reset_writedata", writedata, 64'h0);
        check("reset_alu_grants", 64'(alu_grants), 64'h0);
        check("reset_mem_grants", 64'(mem_grants), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].mv, vecs[i].mrd, vecs[i].md,
                  vecs[i].iv, vecs[i].ird, vecs[i].r1, vecs[i].r2);
            if (vecs[i].iv && vecs[i].ird != '0)
                check($sformatf("v%0d_issue_to_free_reg", i), 64'(tb_pend[vecs[i].ird]), 64'h0);
            #1;
            check($sformatf("v%0d_alu_ready", i), 64'(alu_ready), 64'(vecs[i].e_ar));
            check($sformatf("v%0d_mem_ready", i), 64'(mem_ready), 64'(vecs[i].e_mr));
            check($sformatf("v%0d_stall", i), 64'(stall), 64'(vecs[i].e_st));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_writereg", i), 64'(writereg), 64'(vecs[i].e_wr));
            check($sformatf("v%0d_rd", i), 64'(rd), 64'(vecs[i].e_rd));
            check($sformatf("v%0d_writedata", i), writedata, vecs[i].e_wd);
            check($sformatf("v%0d_alu_grants", i), 64'(alu_grants), 64'(vecs[i].e_ac));
            check($sformatf("v%0d_mem_grants", i), 64'(mem_grants), 64'(vecs[i].e_mc));
            // Shadow of the scoreboard, used only to keep the stimulus legal.
            if (vecs[i].e_ar && vecs[i].ard != '0) tb_pend[vecs[i].ard] = 1'b0;
            if (vecs[i].e_mr && vecs[i].mrd != '0) tb_pend[vecs[i].mrd] = 1'b0;
            if (vecs[i].iv && vecs[i].ird != '0) tb_pend[vecs[i].ird] = 1'b1;
        end

        // Reset the cycle after a transfer: in-flight write, pending bit,
        // counters and arbitration history are all dropped.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
        @(negedge clk);
        drive(1, 4, 64'h44, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rst_seq_alu_ready", 64'(alu_ready), 64'h1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 12, 0);
        reset = 1'b1;
        #1;
        check("rst_seq_inflight_writereg", 64'(writereg), 64'h1);
        check("rst_seq_inflight_rd", 64'(rd), 64'h4);
        check("rst_seq_pending_before", 64'(stall), 64'h1);
        @(posedge clk);
        #1;
        check("rst_seq_writereg", 64'(writereg), 64'h0);
        check("rst_seq_rd", 64'(rd), 64'h0);
        check("rst_seq_writedata", writedata, 64'h0);
        check("rst_seq_alu_grants", 64'(alu_grants), 64'h0);
        check("rst_seq_mem_grants", 64'(mem_grants), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_seq_pending_cleared", 64'(stall), 64'h0);
        @(negedge clk);
        drive(1, 1, 64'h1, 1, 2, 64'h2, 0, 0, 0, 0);
        #1;
        check("rst_seq_tie_alu_ready", 64'(alu_ready), 64'h1);
        check("rst_seq_tie_mem_ready", 64'(mem_ready), 64'h0);
        @(negedge clk);
        #1;
        check("rst_seq_tie2_alu_ready", 64'(alu_ready), 64'h0);
        check("rst_seq_tie2_mem_ready", 64'(mem_ready), 64'h1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Saturation on the 3-bit-counter instance.
        s_alu_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("sat_count_3", 64'(s_alu_grants), 64'h3);
        repeat (7) @(posedge clk);
        #1;
        check("sat_count_held", 64'(s_alu_grants), 64'h7);
        check("sat_mem_idle", 64'(s_mem_grants), 64'h0);
        @(negedge clk);
        s_alu_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Handshake invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            assert (!(alu_ready && mem_ready));
            assert (!alu_ready || alu_valid);
            assert (!mem_ready || mem_valid);
        end
    end

endmodule
